// File: rtl/mul8_op_sequencer.sv
// mul8_op_sequencer: walks a weight-stationary job (cfg_wt_n weights, each
// applied to cfg_act_n activations), feeds operands to an external
// pipelined multiplier and collects its products in a small first-word-
// fall-through FIFO. Issue is gated by FIFO credits so no product is lost.
module mul8_op_sequencer #(
  parameter int LAT   = 2,
  parameter int AW    = 17,
  parameter int DEPTH = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_act_n,
  input  logic [AW-1:0] cfg_wt_n,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] act_addr,
  input  logic [7:0]    act_rdata,
  output logic [AW-1:0] wt_addr,
  input  logic [7:0]    wt_rdata,
  output logic          mul_ena,
  output logic          mul_enb,
  output logic [7:0]    mul_a,
  output logic [7:0]    mul_b,
  input  logic [15:0]   mul_p,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [15:0]   res_data,
  output logic          res_last
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   act_n_q, act_n_d;
  logic [AW-1:0]   wt_n_q, wt_n_d;
  logic [AW-1:0]   w_q, w_d;
  logic [AW-1:0]   k_q, k_d;
  logic [AW-1:0]   base_q, base_d;     // running w*act_n, avoids a multiplier
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // read stage: operand address issued last cycle, data arriving now
  logic            rd_vld_q, rd_vld_d;
  logic            rd_first_q, rd_first_d;
  logic            rd_last_q, rd_last_d;

  // valid/last tracking of operands inside the multiplier
  logic [LAT-1:0]  sr_vld_q, sr_vld_d;
  logic [LAT-1:0]  sr_last_q, sr_last_d;

  // result FIFO
  logic [15:0]     mem_q [DEPTH];
  logic [15:0]     mem_d [DEPTH];
  logic            lst_q [DEPTH];
  logic            lst_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  int              inflight;
  logic            room;
  logic            iss;
  logic            iss_last;
  logic            push;
  logic            pop;

  // operands issued but not yet written into the FIFO
  always_comb begin
    inflight = int'(rd_vld_q);
    for (int i = 0; i < LAT; i++) inflight += int'(sr_vld_q[i]);
  end

  assign room = (int'(cnt_q) + inflight) < DEPTH;
  assign push = sr_vld_q[LAT-1];
  assign pop  = res_valid & res_ready;

  // job control: state, indices and issue decision
  always_comb begin
    state_d  = state_q;
    act_n_d  = act_n_q;
    wt_n_d   = wt_n_q;
    w_d      = w_q;
    k_d      = k_q;
    base_d   = base_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    iss      = 1'b0;
    iss_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          act_n_d = cfg_act_n;
          wt_n_d  = cfg_wt_n;
          w_d     = '0;
          k_d     = '0;
          base_d  = '0;
          busy_d  = 1'b1;
          state_d = (cfg_act_n == '0 || cfg_wt_n == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (room) begin
          iss = 1'b1;
          if (k_q == act_n_q - 1'b1) begin
            k_d    = '0;
            w_d    = w_q + 1'b1;
            base_d = base_q + act_n_q;
            if (w_q == wt_n_q - 1'b1) begin
              iss_last = 1'b1;
              state_d  = S_DRAIN;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (inflight == 0 && cnt_q == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // operand pipeline tracking: read stage then LAT multiplier stages
  always_comb begin
    rd_vld_d     = iss;
    rd_first_d   = iss & (k_q == '0);
    rd_last_d    = iss_last;
    sr_vld_d[0]  = rd_vld_q;
    sr_last_d[0] = rd_last_q;
    for (int i = 1; i < LAT; i++) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_last_d[i] = sr_last_q[i-1];
    end
  end

  // result FIFO: push products as they leave the multiplier, pop on handshake
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      lst_d[i] = lst_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = mul_p;
      lst_d[wr_ptr_q] = sr_last_q[LAT-1];
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // all state, cleared asynchronously so a reset aborts the job silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      act_n_q    <= '0;
      wt_n_q     <= '0;
      w_q        <= '0;
      k_q        <= '0;
      base_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      rd_last_q  <= 1'b0;
      sr_vld_q   <= '0;
      sr_last_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        lst_q[i] <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      act_n_q    <= act_n_d;
      wt_n_q     <= wt_n_d;
      w_q        <= w_d;
      k_q        <= k_d;
      base_q     <= base_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_vld_q   <= rd_vld_d;
      rd_first_q <= rd_first_d;
      rd_last_q  <= rd_last_d;
      sr_vld_q   <= sr_vld_d;
      sr_last_q  <= sr_last_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
        lst_q[i] <= lst_d[i];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign act_addr  = base_q + k_q;
  assign wt_addr   = w_q;
  // buffer data lands in the cycle after issue and goes straight to the multiplier
  assign mul_ena   = rd_vld_q;
  assign mul_enb   = rd_first_q;
  assign mul_a     = rd_vld_q ? act_rdata : '0;
  assign mul_b     = rd_vld_q ? wt_rdata : '0;
  assign res_valid = (cnt_q != '0);
  assign res_data  = res_valid ? mem_q[rd_ptr_q] : '0;
  assign res_last  = res_valid & lst_q[rd_ptr_q];

endmodule

// File: tb/tb_mul8_op_sequencer.sv
// Bench for mul8_op_sequencer: behavioural buffers and multiplier around the
// DUT, golden result queue built from the job definition (act[w*N+k]*wt[w]).
module tb_mul8_op_sequencer;
  localparam int LAT = 2, AW = 17, DEPTH = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_act_n = '0, cfg_wt_n = '0;
  logic          busy, done;
  logic [AW-1:0] act_addr, wt_addr;
  logic [7:0]    act_rdata = '0, wt_rdata = '0;
  logic          mul_ena, mul_enb;
  logic [7:0]    mul_a, mul_b;
  logic [15:0]   mul_p;
  logic          res_valid, res_last;
  logic          res_ready = 1'b1;
  logic [15:0]   res_data;

  int checks = 0, errors = 0;

  mul8_op_sequencer #(.LAT(LAT), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_act_n(cfg_act_n), .cfg_wt_n(cfg_wt_n),
    .busy(busy), .done(done), .act_addr(act_addr), .act_rdata(act_rdata),
    .wt_addr(wt_addr), .wt_rdata(wt_rdata), .mul_ena(mul_ena), .mul_enb(mul_enb),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_last(res_last));

  always #5 clk = ~clk;

  // buffers: synchronous read, one cycle latency
  logic signed [7:0] act_mem [0:16383];
  logic signed [7:0] wt_mem  [0:255];
  always @(posedge clk) begin
    act_rdata <= act_mem[act_addr[13:0]];
    wt_rdata  <= wt_mem[wt_addr[7:0]];
  end

  // weight-stationary multiplier, LAT stages
  logic signed [7:0]  breg = '0;
  logic signed [15:0] mp [LAT];
  always @(posedge clk) begin
    if (mul_enb) breg <= mul_b;
    mp[0] <= $signed(mul_a) * (mul_enb ? $signed(mul_b) : breg);
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign mul_p = mp[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] first_pop;

  // mode 0: ready held 1; 1: random ready + stray start; 2: stall window; 3: abort via reset
  task automatic run_job(input int n, input int m, input int mode, input int abort_at);
    logic [15:0] gq[$];
    bit          gl[$];
    int tot, pops, ena, enb, nval, nlast, first_ena, last_ena, first_val, done_cyc, budget;
    bit fin;
    tot = n * m;
    for (int w = 0; w < m; w++)
      for (int k = 0; k < n; k++) begin
        int p;
        p = int'(act_mem[w*n+k]) * int'(wt_mem[w]);
        gq.push_back(16'(p));
        gl.push_back(w == m-1 && k == n-1);
      end
    pops = 0; ena = 0; enb = 0; nval = 0; nlast = 0;
    first_ena = -1; last_ena = -1; first_val = -1; done_cyc = -1; fin = 0;
    budget = tot * 4 + 100;
    @(negedge clk);
    cfg_act_n = AW'(n); cfg_wt_n = AW'(m); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (mode == 1) res_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) res_ready = !(cyc >= 3 && cyc < 23);
      else res_ready = 1'b1;
      if (mode == 1 && cyc == 5) begin
        start = 1'b1; cfg_act_n = 1; cfg_wt_n = 1;
      end else start = 1'b0;
      if (mul_ena) begin
        ena++;
        if (first_ena < 0) first_ena = cyc;
        last_ena = cyc;
      end
      if (mul_enb) enb++;
      if (res_valid) begin
        nval++;
        if (first_val < 0) first_val = cyc;
      end
      if (res_valid && res_ready) begin
        if (gq.size() == 0) chk("extra_result", 32'(res_data), 32'hdead);
        else begin
          chk("res_data", 32'(res_data), 32'(gq.pop_front()));
          chk("res_last", 32'(res_last), 32'(gl.pop_front()));
        end
        if (res_last) nlast++;
        if (pops == 0) first_pop = res_data;
        pops++;
      end
      if (mode == 2 && cyc == 22)
        chk("stall_outstanding", 32'(ena - pops), 32'(DEPTH));
      if (done) begin
        fin = 1; done_cyc = cyc;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (mode == 3 && pops == abort_at) begin
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_mul", {mul_ena, mul_enb, mul_a, mul_b}, 0);
        chk("abort_res", {res_valid, res_last, res_data}, 0);
        chk("abort_addr", {act_addr, wt_addr[14:0]}, 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b1;
    chk("done_seen", 32'(fin), 32'd1);
    chk("result_count", 32'(pops), 32'(tot));
    chk("golden_empty", 32'(gq.size()), 32'd0);
    chk("ena_count", 32'(ena), 32'(tot));
    chk("enb_count", 32'(enb), 32'(tot > 0 ? m : 0));
    chk("last_count", 32'(nlast), 32'(tot > 0 ? 1 : 0));
    if (tot == 0) begin
      chk("zero_done_cycle", 32'(done_cyc), 32'd1);
      chk("zero_valid_never", 32'(nval), 32'd0);
    end else if (mode == 0) begin
      chk("no_bubbles", 32'(last_ena - first_ena + 1), 32'(tot));
      chk("first_result_lat", 32'(first_val), 32'(LAT + 2));
    end
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16384; i++) act_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)   wt_mem[i]  = 8'($urandom);
  endtask

  initial begin
    fill_random();
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, mul_ena, mul_enb, res_valid, res_last}, 0);
    chk("rst_data", {mul_a, mul_b, res_data}, 0);
    chk("rst_addr", {act_addr, wt_addr[14:0]}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy0", 32'(busy), 0);

    // full-size job, streaming
    run_job(128, 100, 0, 0);

    // extreme operands
    for (int i = 0; i < 4; i++) act_mem[i] = -8'sd128;
    wt_mem[0] = -8'sd128;
    run_job(4, 1, 0, 0);
    chk("neg128_sq", 32'(first_pop), 32'h4000);
    for (int i = 0; i < 4; i++) act_mem[i] = 8'sd127;
    run_job(4, 1, 0, 0);
    chk("p127_n128", 32'(first_pop), 32'hC080);

    // backpressure, random ready with stray start, zero-size jobs
    fill_random();
    run_job(16, 2, 2, 0);
    run_job(7, 3, 1, 0);
    run_job(5, 0, 0, 0);
    run_job(0, 3, 0, 0);
    run_job(1, 1, 0, 0);

    // abort mid-job, then a clean rerun
    run_job(128, 2, 3, 40);
    @(negedge clk);
    chk("post_abort_idle", {busy, done, res_valid}, 0);
    run_job(128, 2, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
